// File: rtl/race_clock.sv
// race_clock: frame-driven race timer producing BCD minutes/seconds.
// Time advances only on frame ticks while running, so the displayed time
// stays locked to rendered video frames. An optional split-time latch is
// built when the macro RACE_CLOCK_SPLIT_EN is defined; without it the split
// outputs are tied to zero and i_split is ignored.
module race_clock #(
   parameter int FRAMES_PER_SEC = 60,
   parameter int MAX_MIN        = 9
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_frame_tick,
   input  logic       i_start,
   input  logic       i_pause,
   input  logic       i_clear,
   input  logic       i_split,
   output logic [3:0] o_min,
   output logic [3:0] o_sec_ten,
   output logic [3:0] o_sec_one,
   output logic [3:0] o_split_min,
   output logic [3:0] o_split_sec_ten,
   output logic [3:0] o_split_sec_one,
   output logic       o_split_valid,
   output logic       o_running,
   output logic       o_done
);

   localparam int              FW            = $clog2(FRAMES_PER_SEC);
   localparam logic [FW-1:0]   LP_FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
   localparam logic [FW-1:0]   LP_FRAME_ONE  = FW'(1);
   localparam logic [3:0]      LP_MAX_MIN    = 4'(MAX_MIN);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t         r_state;
   logic [FW-1:0]  r_frame;
   logic [3:0]     r_min;
   logic [3:0]     r_sec_ten;
   logic [3:0]     r_sec_one;
   logic           r_running;
   logic           r_done;

   // Race state machine, sub-second frame counter and BCD time digits.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_frame   <= {FW{1'b0}};
         r_min     <= 4'd0;
         r_sec_ten <= 4'd0;
         r_sec_one <= 4'd0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else if (i_clear) begin
         // Clear overrides every other pulse, including any tick this cycle.
         r_state   <= ST_IDLE;
         r_frame   <= {FW{1'b0}};
         r_min     <= 4'd0;
         r_sec_ten <= 4'd0;
         r_sec_one <= 4'd0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // A tick coinciding with start is not counted.
               if (i_start) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_RUN: begin
               // Start is meaningless here; pause beats a coinciding tick.
               if (i_pause) begin
                  r_state   <= ST_PAUSE;
                  r_running <= 1'b0;
               end else if (i_frame_tick) begin
                  if (r_frame == LP_FRAME_LAST) begin
                     r_frame <= {FW{1'b0}};
                     if (r_sec_one != 4'd9) begin
                        r_sec_one <= r_sec_one + 4'd1;
                     end else begin
                        r_sec_one <= 4'd0;
                        if (r_sec_ten != 4'd5) begin
                           r_sec_ten <= r_sec_ten + 4'd1;
                        end else begin
                           r_sec_ten <= 4'd0;
                           if (r_min != LP_MAX_MIN) begin
                              r_min <= r_min + 4'd1;
                           end else begin
                              // Past the last displayable second: pin at MAX_MIN:59.
                              r_min     <= LP_MAX_MIN;
                              r_sec_ten <= 4'd5;
                              r_sec_one <= 4'd9;
                              r_state   <= ST_DONE;
                              r_running <= 1'b0;
                              r_done    <= 1'b1;
                           end
                        end
                     end
                  end else begin
                     r_frame <= r_frame + LP_FRAME_ONE;
                  end
               end
            end
            ST_PAUSE: begin
               // Frame counter is held so resuming keeps the sub-second phase.
               if (i_start) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_running <= 1'b0;
               r_done    <= 1'b0;
            end
         endcase
      end
   end

   assign o_min     = r_min;
   assign o_sec_ten = r_sec_ten;
   assign o_sec_one = r_sec_one;
   assign o_running = r_running;
   assign o_done    = r_done;

`ifdef RACE_CLOCK_SPLIT_EN
   logic [3:0] r_split_min;
   logic [3:0] r_split_sec_ten;
   logic [3:0] r_split_sec_one;
   logic       r_split_valid;

   // Split latch: snapshot of the time as it stood before this cycle's update.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_split_min     <= 4'd0;
         r_split_sec_ten <= 4'd0;
         r_split_sec_one <= 4'd0;
         r_split_valid   <= 1'b0;
      end else if (i_clear) begin
         r_split_min     <= 4'd0;
         r_split_sec_ten <= 4'd0;
         r_split_sec_one <= 4'd0;
         r_split_valid   <= 1'b0;
      end else if (i_split && (r_state != ST_IDLE)) begin
         r_split_min     <= r_min;
         r_split_sec_ten <= r_sec_ten;
         r_split_sec_one <= r_sec_one;
         r_split_valid   <= 1'b1;
      end else begin
         r_split_valid   <= r_split_valid;
      end
   end

   assign o_split_min     = r_split_min;
   assign o_split_sec_ten = r_split_sec_ten;
   assign o_split_sec_one = r_split_sec_one;
   assign o_split_valid   = r_split_valid;
`else
   logic w_unused_split;

   assign w_unused_split  = i_split;
   assign o_split_min     = 4'd0;
   assign o_split_sec_ten = 4'd0;
   assign o_split_sec_one = 4'd0;
   assign o_split_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_race_clock.sv
// tb_race_clock: self-checking bench for race_clock. Two instances share the
// stimulus: one with default parameters, one with MAX_MIN=0 for saturation.
// The reference model tracks total counted frames and derives digits from it.
module tb_race_clock;

   localparam int FPS = 60;

   logic clk;
   logic rst_n;
   logic tick, start, pause, clr, split;

   logic [3:0] a_min, a_ten, a_one, a_smin, a_sten, a_sone;
   logic       a_sv, a_run, a_done;
   logic [3:0] b_min, b_ten, b_one, b_smin, b_sten, b_sone;
   logic       b_sv, b_run, b_done;

   int checks = 0;
   int errors = 0;

   // model: state 0 idle, 1 run, 2 pause, 3 done
   int m_st[2];
   int m_frames[2];
   int m_split[2];
   bit m_sv[2];
   int m_maxmin[2];

   race_clock #(.FRAMES_PER_SEC(FPS), .MAX_MIN(9)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_start(start),
      .i_pause(pause), .i_clear(clr), .i_split(split),
      .o_min(a_min), .o_sec_ten(a_ten), .o_sec_one(a_one),
      .o_split_min(a_smin), .o_split_sec_ten(a_sten), .o_split_sec_one(a_sone),
      .o_split_valid(a_sv), .o_running(a_run), .o_done(a_done)
   );

   race_clock #(.FRAMES_PER_SEC(FPS), .MAX_MIN(0)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_start(start),
      .i_pause(pause), .i_clear(clr), .i_split(split),
      .o_min(b_min), .o_sec_ten(b_ten), .o_sec_one(b_one),
      .o_split_min(b_smin), .o_split_sec_ten(b_sten), .o_split_sec_one(b_sone),
      .o_split_valid(b_sv), .o_running(b_run), .o_done(b_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int cur_secs(int i);
      int s, mx;
      s  = m_frames[i] / FPS;
      mx = m_maxmin[i] * 60 + 59;
      return (s > mx) ? mx : s;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0; m_frames[i] = 0; m_split[i] = 0; m_sv[i] = 1'b0;
      end
      m_maxmin[0] = 9;
      m_maxmin[1] = 0;
   endfunction

   function automatic void model_step(int i, bit t, bit s, bit p, bit c, bit sp);
      if (c) begin
         m_st[i] = 0; m_frames[i] = 0; m_split[i] = 0; m_sv[i] = 1'b0;
      end else begin
         if (sp && m_st[i] != 0) begin
            m_split[i] = cur_secs(i);
            m_sv[i]    = 1'b1;
         end
         if ((m_st[i] == 0 || m_st[i] == 2) && s) begin
            m_st[i] = 1;
         end else if (m_st[i] == 1 && p) begin
            m_st[i] = 2;
         end else if (m_st[i] == 1 && t) begin
            m_frames[i] = m_frames[i] + 1;
            if (m_frames[i] / FPS > m_maxmin[i] * 60 + 59) m_st[i] = 3;
         end
      end
   endfunction

   function automatic logic [26:0] model_vec(int i);
      int s, sp;
      bit sv;
      s = cur_secs(i);
`ifdef RACE_CLOCK_SPLIT_EN
      sp = m_split[i];
      sv = m_sv[i];
`else
      sp = 0;
      sv = 1'b0;
`endif
      return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10),
              4'(sp / 60), 4'((sp % 60) / 10), 4'(sp % 10),
              sv, (m_st[i] == 1), (m_st[i] == 3)};
   endfunction

   function automatic logic [26:0] obs_vec(int i);
      if (i == 0)
         return {a_min, a_ten, a_one, a_smin, a_sten, a_sone, a_sv, a_run, a_done};
      else
         return {b_min, b_ten, b_one, b_smin, b_sten, b_sone, b_sv, b_run, b_done};
   endfunction

   task automatic cycle(input bit t, input bit s, input bit p, input bit c, input bit sp);
      tick = t; start = s; pause = p; clr = c; split = sp;
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i, t, s, p, c, sp);
      #1;
      tick = 1'b0; start = 1'b0; pause = 1'b0; clr = 1'b0; split = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      tick = 1'b0; start = 1'b0; pause = 1'b0; clr = 1'b0; split = 1'b0;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs_vec(i) !== 27'd0) begin
            errors++;
            $display("FAIL reset dut%0d got %h want 0", i, obs_vec(i));
         end
      end
   endtask

   task automatic test_counting();
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(59);
      checks++;
      if (a_sec_one_is(4'd0) !== 1'b1) begin
         errors++;
         $display("FAIL count59 got sec_one %0d want 0", a_one);
      end
      ticks(1);
      checks++;
      if (a_one !== 4'd1 || a_ten !== 4'd0 || a_run !== 1'b1) begin
         errors++;
         $display("FAIL count60 got %0d%0d run %b want 01 run 1", a_ten, a_one, a_run);
      end
      ticks(540);
      checks++;
      if (a_ten !== 4'd1 || a_one !== 4'd0 || a_min !== 4'd0) begin
         errors++;
         $display("FAIL count600 got %0d:%0d%0d want 0:10", a_min, a_ten, a_one);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs_vec(i) !== model_vec(i)) begin
            errors++;
            $display("FAIL counting dut%0d got %h want %h", i, obs_vec(i), model_vec(i));
         end
      end
   endtask

   function automatic bit a_sec_one_is(logic [3:0] v);
      return (a_one === v);
   endfunction

   task automatic test_pause_resume();
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(30);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (a_run !== 1'b0) begin
         errors++;
         $display("FAIL pause_run got %b want 0", a_run);
      end
      ticks(100);
      checks++;
      if (a_one !== 4'd0) begin
         errors++;
         $display("FAIL pause_hold got sec_one %0d want 0", a_one);
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(29);
      checks++;
      if (a_one !== 4'd0) begin
         errors++;
         $display("FAIL resume29 got sec_one %0d want 0", a_one);
      end
      ticks(1);
      checks++;
      if (a_min !== 4'd0 || a_ten !== 4'd0 || a_one !== 4'd1 || a_run !== 1'b1) begin
         errors++;
         $display("FAIL resume got %0d:%0d%0d run %b want 0:01 run 1", a_min, a_ten, a_one, a_run);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs_vec(i) !== model_vec(i)) begin
            errors++;
            $display("FAIL pause dut%0d got %h want %h", i, obs_vec(i), model_vec(i));
         end
      end
   endtask

   task automatic test_saturation();
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(3599);
      checks++;
      if (b_min !== 4'd0 || b_ten !== 4'd5 || b_one !== 4'd9 || b_run !== 1'b1 || b_done !== 1'b0) begin
         errors++;
         $display("FAIL sat3599 got %0d:%0d%0d run %b done %b want 0:59 run 1 done 0",
                  b_min, b_ten, b_one, b_run, b_done);
      end
      ticks(1);
      checks++;
      if (b_min !== 4'd0 || b_ten !== 4'd5 || b_one !== 4'd9 || b_run !== 1'b0 || b_done !== 1'b1) begin
         errors++;
         $display("FAIL sat3600 got %0d:%0d%0d run %b done %b want 0:59 run 0 done 1",
                  b_min, b_ten, b_one, b_run, b_done);
      end
      checks++;
      if (a_min !== 4'd1 || a_ten !== 4'd0 || a_one !== 4'd0) begin
         errors++;
         $display("FAIL minute_roll got %0d:%0d%0d want 1:00", a_min, a_ten, a_one);
      end
      ticks(50);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (b_min !== 4'd0 || b_ten !== 4'd5 || b_one !== 4'd9 || b_done !== 1'b1 || b_run !== 1'b0) begin
         errors++;
         $display("FAIL sat_hold got %0d:%0d%0d done %b want 0:59 done 1", b_min, b_ten, b_one, b_done);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs_vec(i) !== model_vec(i)) begin
            errors++;
            $display("FAIL saturation dut%0d got %h want %h", i, obs_vec(i), model_vec(i));
         end
      end
   endtask

   task automatic test_coincide();
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(75);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (a_min !== 4'd0 || a_ten !== 4'd0 || a_one !== 4'd0 || a_run !== 1'b0 || a_done !== 1'b0) begin
         errors++;
         $display("FAIL coincide got %0d:%0d%0d run %b want 0:00 run 0", a_min, a_ten, a_one, a_run);
      end
      // tick ignored in IDLE, then start+tick does not count
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(59);
      checks++;
      if (a_one !== 4'd0 || a_run !== 1'b1) begin
         errors++;
         $display("FAIL start_tick got sec_one %0d run %b want 0 run 1", a_one, a_run);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs_vec(i) !== model_vec(i)) begin
            errors++;
            $display("FAIL coincide dut%0d got %h want %h", i, obs_vec(i), model_vec(i));
         end
      end
   endtask

   task automatic test_split();
      logic [3:0] e_smin, e_sten, e_sone;
      logic       e_sv;
`ifdef RACE_CLOCK_SPLIT_EN
      e_smin = 4'd1; e_sten = 4'd2; e_sone = 4'd3; e_sv = 1'b1;
`else
      e_smin = 4'd0; e_sten = 4'd0; e_sone = 4'd0; e_sv = 1'b0;
`endif
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (a_sv !== 1'b0) begin
         errors++;
         $display("FAIL split_idle got valid %b want 0", a_sv);
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(5039);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (a_min !== 4'd1 || a_ten !== 4'd2 || a_one !== 4'd4) begin
         errors++;
         $display("FAIL split_live got %0d:%0d%0d want 1:24", a_min, a_ten, a_one);
      end
      checks++;
      if (a_smin !== e_smin || a_sten !== e_sten || a_sone !== e_sone || a_sv !== e_sv) begin
         errors++;
         $display("FAIL split_val got %0d:%0d%0d v%b want %0d:%0d%0d v%b",
                  a_smin, a_sten, a_sone, a_sv, e_smin, e_sten, e_sone, e_sv);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs_vec(i) !== model_vec(i)) begin
            errors++;
            $display("FAIL split dut%0d got %h want %h", i, obs_vec(i), model_vec(i));
         end
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (a_sv !== 1'b0 || b_sv !== 1'b0) begin
         errors++;
         $display("FAIL split_clear got valid %b/%b want 0/0", a_sv, b_sv);
      end
   endtask

   task automatic test_random();
      bit t, s, p, c, sp;
      for (int k = 0; k < 4000; k++) begin
         if (k % 1300 == 1299) begin
            do_reset();
         end else begin
            t  = ($urandom_range(0, 1) == 0);
            s  = ($urandom_range(0, 19) == 0);
            p  = ($urandom_range(0, 29) == 0);
            c  = ($urandom_range(0, 399) == 0);
            sp = ($urandom_range(0, 24) == 0);
            cycle(t, s, p, c, sp);
         end
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== model_vec(i)) begin
               errors++;
               $display("FAIL random dut%0d cyc %0d got %h want %h", i, k, obs_vec(i), model_vec(i));
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      test_reset();
      test_counting();
      test_pause_resume();
      test_saturation();
      test_coincide();
      test_split();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
